// File: rtl/iob_vexriscv_bus_merge_pkg.sv
// Shared types and helpers for the VexRiscv instruction/data IOb bus merger.
// Requests are packed {avalid, addr, wdata, wstrb}; responses are {rdata, rvalid, ready}.
package iob_vexriscv_bus_merge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } merge_state_t;

    localparam logic OWNER_IBUS = 1'b0;
    localparam logic OWNER_DBUS = 1'b1;

    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_width(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/iob_reg_re.sv
// Generic register with clock enable, synchronous reset and load enable.
module iob_reg_re #(
    parameter int                 DATA_W  = 1,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    // Storage: async clear, then sync clear or load while the clock is enabled.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_o <= RST_VAL;
        end else if (cke_i) begin
            if (rst_i) begin
                data_o <= RST_VAL;
            end else if (en_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/iob_vexriscv_merge_arb.sv
// Grant logic for the bus merger: fixed dbus priority, or round-robin with a
// last_grant register when IOB_VEX_MERGE_RR_EN is defined.
module iob_vexriscv_merge_arb
    import iob_vexriscv_bus_merge_pkg::*;
(
`ifdef IOB_VEX_MERGE_RR_EN
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic cke_i,
    input  logic grant,
`endif
    input  logic ibus_avalid,
    input  logic dbus_avalid,
    output logic gnt_valid,
    output logic gnt_owner
);

    logic prio_s;

`ifdef IOB_VEX_MERGE_RR_EN
    logic last_grant_r;

    // On a conflict the requester that did not win last time goes first.
    assign prio_s = ~last_grant_r;

    // Remember which requester took the most recent grant.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            last_grant_r <= OWNER_IBUS;
        end else if (cke_i && grant) begin
            last_grant_r <= gnt_owner;
        end
    end
`else
    assign prio_s = OWNER_DBUS;
`endif

    // Winner selection; a lone requester always wins.
    always_comb begin
        gnt_valid = ibus_avalid | dbus_avalid;
        if (ibus_avalid && dbus_avalid) begin
            gnt_owner = prio_s;
        end else if (dbus_avalid) begin
            gnt_owner = OWNER_DBUS;
        end else begin
            gnt_owner = OWNER_IBUS;
        end
    end

endmodule

// File: rtl/iob_vexriscv_bus_merge.sv
// Merges the VexRiscv instruction and data IOb ports onto one IOb master with a
// single outstanding read. Optional round-robin arbitration: IOB_VEX_MERGE_RR_EN.
module iob_vexriscv_bus_merge
    import iob_vexriscv_bus_merge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REQ_W  = req_width(ADDR_W, DATA_W),
    parameter int RESP_W = resp_width(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic [REQ_W-1:0]  ibus_req_i,
    output logic [RESP_W-1:0] ibus_resp_o,
    input  logic [REQ_W-1:0]  dbus_req_i,
    output logic [RESP_W-1:0] dbus_resp_o,
    output logic [REQ_W-1:0]  m_req_o,
    input  logic [RESP_W-1:0] m_resp_i,
    output logic              err_o
);

    localparam int STRB_W     = DATA_W / 8;
    localparam int AVALID_BIT = REQ_W - 1;
    localparam int READY_BIT  = 0;
    localparam int RVALID_BIT = 1;
    localparam int RDATA_LSB  = 2;

    merge_state_t      state_r;
    merge_state_t      state_nxt_s;
    logic [REQ_W-1:0]  req_r;
    logic [REQ_W-1:0]  win_req_s;
    logic              owner_r;
    logic              is_rd_r;
    logic              err_r;
    logic              gnt_valid_s;
    logic              gnt_owner_s;
    logic              grant_s;
    logic              is_rd_nxt_s;
    logic              err_set_s;
    logic              m_ready_s;
    logic              m_rvalid_s;
    logic [DATA_W-1:0] m_rdata_s;

    assign m_ready_s   = m_resp_i[READY_BIT];
    assign m_rvalid_s  = m_resp_i[RVALID_BIT];
    assign m_rdata_s   = m_resp_i[RDATA_LSB +: DATA_W];
    assign win_req_s   = gnt_owner_s ? dbus_req_i : ibus_req_i;
    assign is_rd_nxt_s = (win_req_s[STRB_W-1:0] == {STRB_W{1'b0}});
    // Any m rvalid without a read in flight is a slave protocol error.
    assign err_set_s   = m_rvalid_s && (state_r != WAIT_R);
    assign err_o       = err_r;

    iob_vexriscv_merge_arb u_arb (
`ifdef IOB_VEX_MERGE_RR_EN
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .cke_i       (cke_i),
        .grant       (grant_s),
`endif
        .ibus_avalid (ibus_req_i[AVALID_BIT]),
        .dbus_avalid (dbus_req_i[AVALID_BIT]),
        .gnt_valid   (gnt_valid_s),
        .gnt_owner   (gnt_owner_s)
    );

    iob_reg_re #(.DATA_W(REQ_W)) u_req_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(1'b0),
        .en_i(grant_s), .data_i(win_req_s), .data_o(req_r)
    );

    iob_reg_re #(.DATA_W(1)) u_owner_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(1'b0),
        .en_i(grant_s), .data_i(gnt_owner_s), .data_o(owner_r)
    );

    iob_reg_re #(.DATA_W(1)) u_is_rd_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(1'b0),
        .en_i(grant_s), .data_i(is_rd_nxt_s), .data_o(is_rd_r)
    );

    iob_reg_re #(.DATA_W(1)) u_err_reg (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_i(1'b0),
        .en_i(err_set_s), .data_i(1'b1), .data_o(err_r)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= IDLE;
        end else if (cke_i) begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, grant strobe and response routing to the owning requester.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        m_req_o     = '0;
        ibus_resp_o = '0;
        dbus_resp_o = '0;
        ibus_resp_o[RDATA_LSB +: DATA_W] = m_rdata_s;
        dbus_resp_o[RDATA_LSB +: DATA_W] = m_rdata_s;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    grant_s     = 1'b1;
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                m_req_o             = req_r;
                m_req_o[AVALID_BIT] = 1'b1;
                if (owner_r == OWNER_DBUS) begin
                    dbus_resp_o[READY_BIT] = m_ready_s;
                end else begin
                    ibus_resp_o[READY_BIT] = m_ready_s;
                end
                if (m_ready_s) begin
                    state_nxt_s = is_rd_r ? WAIT_R : IDLE;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT_R: begin
                if (owner_r == OWNER_DBUS) begin
                    dbus_resp_o[RVALID_BIT] = m_rvalid_s;
                end else begin
                    ibus_resp_o[RVALID_BIT] = m_rvalid_s;
                end
                if (m_rvalid_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_R;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iob_vexriscv_bus_merge.sv
// Self-checking bench for iob_vexriscv_bus_merge: scripted requesters, a
// configurable slave model and a scoreboard of expected master requests/read data.
module tb_iob_vexriscv_bus_merge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int RQW = 1 + AW + DW + DW / 8;
    localparam int RSW = DW + 2;
    localparam int AV  = RQW - 1;

    logic           clk = 1'b0;
    logic           arst_n;
    logic           cke;
    logic [RQW-1:0] ibus_req, dbus_req, m_req;
    logic [RSW-1:0] ibus_resp, dbus_resp, m_resp;
    logic           err;

    iob_vexriscv_bus_merge dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .cke_i       (cke),
        .ibus_req_i  (ibus_req),
        .ibus_resp_o (ibus_resp),
        .dbus_req_i  (dbus_req),
        .dbus_resp_o (dbus_resp),
        .m_req_o     (m_req),
        .m_resp_i    (m_resp),
        .err_o       (err)
    );

    initial forever #5 clk = ~clk;

    // ---------------- slave model ----------------
    int          ready_wait = 0;
    int          rvalid_delay = 0;
    logic        spur = 1'b0;
    int          wcnt;
    logic        rd_pend;
    int          rd_cnt;
    logic [31:0] rd_data;
    logic        s_ready, s_rvalid, m_av, m_wr;
    logic [31:0] m_addr;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0], 16'h5A5A} ^ 32'h0F0F_0000;
    endfunction

    function automatic logic [RQW-1:0] mk_req(input logic av, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] s);
        return {av, a, d, s};
    endfunction

    assign m_av     = m_req[AV];
    assign m_wr     = |m_req[3:0];
    assign m_addr   = m_req[67:36];
    assign s_ready  = m_av && (wcnt >= ready_wait);
    assign s_rvalid = (rd_pend && rd_cnt == 0) || spur;
    assign m_resp   = {rd_data, s_rvalid, s_ready};

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wcnt <= 0; rd_pend <= 1'b0; rd_cnt <= 0; rd_data <= 32'h0;
        end else begin
            if (m_av && s_ready) wcnt <= 0;
            else if (m_av)       wcnt <= wcnt + 1;
            if (m_av && s_ready && !m_wr) begin
                rd_pend <= 1'b1; rd_cnt <= rvalid_delay; rd_data <= rdata_of(m_addr);
            end else if (rd_pend && rd_cnt == 0) begin
                rd_pend <= 1'b0;
            end else if (rd_pend) begin
                rd_cnt <= rd_cnt - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [RQW-1:0] exp_m[$];
    logic [31:0]    exp_i[$];
    logic [31:0]    exp_d[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    logic           i_acc = 1'b0, d_acc = 1'b0;

    initial begin
        logic [RQW-1:0] em;
        logic [31:0]    ed;
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (m_av && s_ready) begin
                    n_cmp++;
                    if (exp_m.size() == 0) begin
                        n_bad++; $display("FAIL m_req_order got=%h required=<none>", m_req);
                    end else begin
                        em = exp_m.pop_front();
                        if (m_req !== em) begin
                            n_bad++; $display("FAIL m_req_order got=%h required=%h", m_req, em);
                        end
                    end
                end
                if (ibus_resp[1]) begin
                    n_cmp++;
                    if (exp_i.size() == 0) begin
                        n_bad++; $display("FAIL ibus_rdata got=%h required=<no rvalid>", ibus_resp[33:2]);
                    end else begin
                        ed = exp_i.pop_front();
                        if (ibus_resp[33:2] !== ed) begin
                            n_bad++; $display("FAIL ibus_rdata got=%h required=%h", ibus_resp[33:2], ed);
                        end
                    end
                end
                if (dbus_resp[1]) begin
                    n_cmp++;
                    if (exp_d.size() == 0) begin
                        n_bad++; $display("FAIL dbus_rdata got=%h required=<no rvalid>", dbus_resp[33:2]);
                    end else begin
                        ed = exp_d.pop_front();
                        if (dbus_resp[33:2] !== ed) begin
                            n_bad++; $display("FAIL dbus_rdata got=%h required=%h", dbus_resp[33:2], ed);
                        end
                    end
                end
            end
        end
    end

    // Advance one cycle; requesters release avalid after a sampled ready.
    task automatic tick();
        @(posedge clk); #1;
        if (i_acc) ibus_req = '0;
        if (d_acc) dbus_req = '0;
        @(negedge clk);
        i_acc = ibus_req[AV] && ibus_resp[0];
        d_acc = dbus_req[AV] && dbus_resp[0];
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (exp_m.size() == 0 && exp_i.size() == 0 && exp_d.size() == 0 &&
                !ibus_req[AV] && !dbus_req[AV]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        arst_n = 1'b0; cke = 1'b1; ibus_req = '0;
        dbus_req = mk_req(1'b1, 32'h40, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (m_req !== '0) begin n_bad++; $display("FAIL reset_m_req got=%h required=0", m_req); end
        n_cmp++;
        if ({ibus_resp[1:0], dbus_resp[1:0], err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got=%b required=00000", {ibus_resp[1:0], dbus_resp[1:0], err});
        end
        dbus_req = '0;
        arst_n = 1'b1;
        tick();
        n_cmp++;
        if (m_req !== '0) begin n_bad++; $display("FAIL reset_idle got=%h required=0", m_req); end
    endtask

    task automatic test_single_read();
        bit ok;
        ibus_req = mk_req(1'b1, 32'h100, 32'h0, 4'h0);
        exp_m.push_back(ibus_req);
        exp_i.push_back(32'hDEAD_BEEF);
        n_cmp++;
        if (m_av !== 1'b0) begin n_bad++; $display("FAIL single_t0_avalid got=%b required=0", m_av); end
        tick();
        n_cmp++;
        if ({m_av, ibus_resp[0], dbus_resp[0]} !== 3'b110) begin
            n_bad++; $display("FAIL single_t1 {av,irdy,drdy} got=%b required=110", {m_av, ibus_resp[0], dbus_resp[0]});
        end
        tick();
        n_cmp++;
        if ({ibus_resp[1], dbus_resp[1], m_av} !== 3'b100 || ibus_resp[33:2] !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL single_t2 {irv,drv,av}=%b rdata=%h required=100 deadbeef",
                              {ibus_resp[1], dbus_resp[1], m_av}, ibus_resp[33:2]);
        end
        tick();
        n_cmp++;
        if (ibus_resp[1] !== 1'b0) begin n_bad++; $display("FAIL single_rvalid_pulse got=1 required=0"); end
        drain(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_drain got=timeout required=done"); end
    endtask

    task automatic test_conflict();
        bit ok;
        logic [RQW-1:0] ireq, dreq2;
        logic [1:0]     exp_rdy;
        ibus_req = mk_req(1'b1, 32'h0, 32'h0, 4'h0);
        dbus_req = mk_req(1'b1, 32'h80, 32'h1234_5678, 4'hF);
        ireq = ibus_req;
        exp_m.push_back(dbus_req);
        exp_i.push_back(rdata_of(32'h0));
        tick();
        n_cmp++;
        if ({ibus_resp[0], dbus_resp[0]} !== 2'b01) begin
            n_bad++; $display("FAIL conflict_first {irdy,drdy} got=%b required=01", {ibus_resp[0], dbus_resp[0]});
        end
        tick();
        n_cmp++;
        if ({ibus_resp[0], m_av} !== 2'b00) begin
            n_bad++; $display("FAIL conflict_gap {irdy,av} got=%b required=00", {ibus_resp[0], m_av});
        end
        dbus_req = mk_req(1'b1, 32'h84, 32'h0BAD_F00D, 4'h3);
        dreq2 = dbus_req;
`ifdef IOB_VEX_MERGE_RR_EN
        exp_m.push_back(ireq); exp_m.push_back(dreq2); exp_rdy = 2'b10;
`else
        exp_m.push_back(dreq2); exp_m.push_back(ireq); exp_rdy = 2'b01;
`endif
        tick();
        n_cmp++;
        if ({ibus_resp[0], dbus_resp[0]} !== exp_rdy) begin
            n_bad++; $display("FAIL conflict_second {irdy,drdy} got=%b required=%b", {ibus_resp[0], dbus_resp[0]}, exp_rdy);
        end
        drain(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL conflict_drain got=timeout required=done"); end
    endtask

    task automatic test_wait_write();
        logic [RQW-1:0] e;
        int n_av = 0, n_rdy = 0, n_rv = 0;
        bit stable = 1'b1;
        ready_wait = 5;
        dbus_req = mk_req(1'b1, 32'h200, 32'hCAFE_F00D, 4'h3);
        e = dbus_req;
        exp_m.push_back(e);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (m_av) begin n_av++; if (m_req !== e) stable = 1'b0; end
            if (dbus_resp[0]) n_rdy++;
            if (ibus_resp[1] || dbus_resp[1] || ibus_resp[0]) n_rv++;
        end
        ready_wait = 0;
        n_cmp++;
        if (n_av != 6 || !stable) begin
            n_bad++; $display("FAIL wait_write_hold cycles=%0d stable=%0d required=6 1", n_av, stable);
        end
        n_cmp++;
        if (n_rdy != 1) begin n_bad++; $display("FAIL wait_write_ready_pulses got=%0d required=1", n_rdy); end
        n_cmp++;
        if (n_rv != 0) begin n_bad++; $display("FAIL wait_write_stray got=%0d required=0", n_rv); end
    endtask

    task automatic test_delayed_read();
        bit ok;
        int rv_k = -1, early = 0;
        rvalid_delay = 10;
        dbus_req = mk_req(1'b1, 32'h300, 32'h0, 4'h0);
        exp_m.push_back(dbus_req);
        exp_d.push_back(rdata_of(32'h300));
        tick();
        ibus_req = mk_req(1'b1, 32'h40, 32'h0, 4'h0);
        exp_m.push_back(ibus_req);
        exp_i.push_back(rdata_of(32'h40));
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ibus_resp[0] || ibus_resp[1]) early++;
            if (dbus_resp[1]) begin rv_k = k; break; end
        end
        rvalid_delay = 0;
        n_cmp++;
        if (rv_k != 10) begin n_bad++; $display("FAIL delayed_rvalid_cycle got=%0d required=10", rv_k); end
        n_cmp++;
        if (early != 0) begin n_bad++; $display("FAIL delayed_ibus_blocked got=%0d required=0", early); end
        tick();
        n_cmp++;
        if (ibus_resp[0] !== 1'b0) begin n_bad++; $display("FAIL delayed_idle_rdy got=1 required=0"); end
        tick();
        n_cmp++;
        if (ibus_resp[0] !== 1'b1) begin n_bad++; $display("FAIL delayed_ibus_grant got=0 required=1"); end
        drain(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL delayed_drain got=timeout required=done"); end
    endtask

    task automatic test_spurious();
        spur = 1'b1;
        n_cmp++;
        if ({ibus_resp[1], dbus_resp[1], err} !== 3'b000) begin
            n_bad++; $display("FAIL spurious_route {irv,drv,err} got=%b required=000", {ibus_resp[1], dbus_resp[1], err});
        end
        tick();
        spur = 1'b0;
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL spurious_err got=%b required=1", err); end
        repeat (4) tick();
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL spurious_sticky got=%b required=1", err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        rvalid_delay = 5;
        ibus_req = mk_req(1'b1, 32'h500, 32'h0, 4'h0);
        exp_m.push_back(ibus_req);
        exp_i.push_back(rdata_of(32'h500));
        tick();
        tick();
        n_cmp++;
        if ({m_av, ibus_resp[1]} !== 2'b00) begin
            n_bad++; $display("FAIL midrst_wait {av,irv} got=%b required=00", {m_av, ibus_resp[1]});
        end
        arst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_req !== '0 || {ibus_resp[1:0], dbus_resp[1:0], err} !== 5'b0) begin
            n_bad++; $display("FAIL midrst_outputs m_req=%h flags=%b required=0 00000",
                              m_req, {ibus_resp[1:0], dbus_resp[1:0], err});
        end
        exp_i.delete();
        ibus_req = '0; i_acc = 1'b0; d_acc = 1'b0;
        rvalid_delay = 0;
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        ibus_req = mk_req(1'b1, 32'h100, 32'h0, 4'h0);
        exp_m.push_back(ibus_req);
        exp_i.push_back(32'hDEAD_BEEF);
        tick();
        n_cmp++;
        if (ibus_resp[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_regrant got=0 required=1"); end
        drain(ok);
        n_cmp++;
        if (!ok || err !== 1'b0) begin
            n_bad++; $display("FAIL midrst_recover done=%0d err=%b required=1 0", ok, err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_conflict();
        test_wait_write();
        test_delayed_read();
        test_spurious();
        test_reset_mid();
        n_cmp++;
        if (exp_m.size() != 0 || exp_i.size() != 0 || exp_d.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_leftover got=%0d/%0d/%0d required=0/0/0",
                              exp_m.size(), exp_i.size(), exp_d.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
